// File: rtl/hv_timing_gen.sv
// hv_timing_gen: horizontal/vertical video timing generator with gated pixel path.
// Optional sync shift ports enabled by defining HV_TIMING_GEN_SHIFT_EN.
module hv_timing_gen #(
    parameter int CW       = 9,
    parameter int HACT     = 288,
    parameter int HFP      = 22,
    parameter int HSW      = 32,
    parameter int HBP      = 42,
    parameter int VACT     = 224,
    parameter int VFP      = 12,
    parameter int VSW      = 7,
    parameter int VBP      = 20,
    parameter int SYNC_POL = 0,
    parameter int PW       = 12
) (
    input  logic          MCLK,
    input  logic          RESET_N,
    input  logic          PCE,
    input  logic [PW-1:0] iRGB,
    output logic [CW-1:0] HPOS,
    output logic [CW-1:0] VPOS,
    output logic [PW-1:0] oRGB,
    output logic          HBLK,
    output logic          VBLK,
    output logic          HSYN,
    output logic          VSYN,
    output logic          LSTART,
    output logic          FSTART
`ifdef HV_TIMING_GEN_SHIFT_EN
   ,input  logic signed [3:0] HSHIFT,
    input  logic signed [3:0] VSHIFT
`endif
);

    localparam int HTOT     = HACT + HFP + HSW + HBP;
    localparam int VTOT     = VACT + VFP + VSW + VBP;
    localparam int HS_START = HACT + HFP;
    localparam int HS_END   = HACT + HFP + HSW;
    localparam int VS_START = VACT + VFP;
    localparam int VS_END   = VACT + VFP + VSW;

    localparam logic [CW-1:0] HLAST = CW'(HTOT - 1);
    localparam logic [CW-1:0] VLAST = CW'(VTOT - 1);
    localparam logic          SACT  = (SYNC_POL != 0);

    logic [1:0]    rst_sync_q, rst_sync_d;
    logic          tick;
    logic          hwrap, vwrap;
    logic          hblk_n, vblk_n, hs_on, vs_on;
    logic signed [3:0] hsh, vsh;

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic [PW-1:0] rgb_q, rgb_d;
    logic          hblk_q, hblk_d;
    logic          vblk_q, vblk_d;
    logic          hsyn_q, hsyn_d;
    logic          vsyn_q, vsyn_d;
    logic          lstart_q, lstart_d;
    logic          fstart_q, fstart_d;

    // Reset release shifts through two flops before counting is allowed.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    // Reset synchroniser register.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) rst_sync_q <= 2'b00;
        else          rst_sync_q <= rst_sync_d;
    end

    assign tick  = PCE & rst_sync_q[1];
    assign hwrap = (hcnt_q == HLAST);
    assign vwrap = (vcnt_q == VLAST);

`ifdef HV_TIMING_GEN_SHIFT_EN
    logic signed [3:0] hsh_q, hsh_d;
    logic signed [3:0] vsh_q, vsh_d;

    // Shifts are captured only at the frame boundary.
    always_comb begin
        hsh_d = hsh_q;
        vsh_d = vsh_q;
        if (tick && hwrap && vwrap) begin
            hsh_d = HSHIFT;
            vsh_d = VSHIFT;
        end
    end

    // Latched shift registers.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hsh_q <= 4'sd0;
            vsh_q <= 4'sd0;
        end else begin
            hsh_q <= hsh_d;
            vsh_q <= vsh_d;
        end
    end

    assign hsh = hsh_q;
    assign vsh = vsh_q;
`else
    assign hsh = 4'sd0;
    assign vsh = 4'sd0;
`endif

    // Decode blank/sync windows from the pre-increment counters.
    always_comb begin
        hblk_n = (int'(hcnt_q) >= HACT);
        vblk_n = (int'(vcnt_q) >= VACT);
        hs_on  = (int'(hcnt_q) >= HS_START + int'(hsh)) &&
                 (int'(hcnt_q) <  HS_END   + int'(hsh));
        vs_on  = (int'(vcnt_q) >= VS_START + int'(vsh)) &&
                 (int'(vcnt_q) <  VS_END   + int'(vsh));
    end

    // Counter advance and registered outputs, all qualified by the pixel tick.
    always_comb begin
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        rgb_d    = rgb_q;
        hblk_d   = hblk_q;
        vblk_d   = vblk_q;
        hsyn_d   = hsyn_q;
        vsyn_d   = vsyn_q;
        lstart_d = 1'b0;
        fstart_d = 1'b0;
        if (tick) begin
            if (hwrap) begin
                hcnt_d = '0;
                vcnt_d = vwrap ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
            hblk_d   = hblk_n;
            vblk_d   = vblk_n;
            hsyn_d   = hs_on ? SACT : ~SACT;
            vsyn_d   = vs_on ? SACT : ~SACT;
            rgb_d    = (hblk_n | vblk_n) ? '0 : iRGB;
            lstart_d = hwrap;
            fstart_d = hwrap & vwrap;
        end
    end

    // Timing state registers.
    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            rgb_q    <= '0;
            hblk_q   <= 1'b1;
            vblk_q   <= 1'b1;
            hsyn_q   <= ~SACT;
            vsyn_q   <= ~SACT;
            lstart_q <= 1'b0;
            fstart_q <= 1'b0;
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            rgb_q    <= rgb_d;
            hblk_q   <= hblk_d;
            vblk_q   <= vblk_d;
            hsyn_q   <= hsyn_d;
            vsyn_q   <= vsyn_d;
            lstart_q <= lstart_d;
            fstart_q <= fstart_d;
        end
    end

    assign HPOS   = hcnt_q;
    assign VPOS   = vcnt_q;
    assign oRGB   = rgb_q;
    assign HBLK   = hblk_q;
    assign VBLK   = vblk_q;
    assign HSYN   = hsyn_q;
    assign VSYN   = vsyn_q;
    assign LSTART = lstart_q;
    assign FSTART = fstart_q;

endmodule

// File: tb/tb_hv_timing_gen.sv
// tb_hv_timing_gen: random-PCE bench for hv_timing_gen, default and small configs.
// Expected outputs come from a tick-count model of the raster.
module tb_hv_timing_gen;

    logic        MCLK    = 1'b0;
    logic        RESET_N = 1'b0;
    logic        PCE     = 1'b0;
    logic [11:0] iRGB    = '0;

    logic [8:0]  d_hpos, d_vpos;
    logic [11:0] d_rgb;
    logic        d_hblk, d_vblk, d_hsyn, d_vsyn, d_ls, d_fs;

    logic [4:0]  s_hpos, s_vpos;
    logic [11:0] s_rgb;
    logic        s_hblk, s_vblk, s_hsyn, s_vsyn, s_ls, s_fs;

    always #5 MCLK = ~MCLK;

    hv_timing_gen u_def (
        .MCLK(MCLK), .RESET_N(RESET_N), .PCE(PCE), .iRGB(iRGB),
        .HPOS(d_hpos), .VPOS(d_vpos), .oRGB(d_rgb),
        .HBLK(d_hblk), .VBLK(d_vblk), .HSYN(d_hsyn), .VSYN(d_vsyn),
        .LSTART(d_ls), .FSTART(d_fs)
    );

    hv_timing_gen #(
        .CW(5), .HACT(12), .HFP(5), .HSW(6), .HBP(9),
        .VACT(10), .VFP(4), .VSW(3), .VBP(5), .SYNC_POL(1), .PW(12)
    ) u_sml (
        .MCLK(MCLK), .RESET_N(RESET_N), .PCE(PCE), .iRGB(iRGB),
        .HPOS(s_hpos), .VPOS(s_vpos), .oRGB(s_rgb),
        .HBLK(s_hblk), .VBLK(s_vblk), .HSYN(s_hsyn), .VSYN(s_vsyn),
        .LSTART(s_ls), .FSTART(s_fs)
    );

    localparam int HA[2]  = '{288, 12};
    localparam int HF[2]  = '{22, 5};
    localparam int HW[2]  = '{32, 6};
    localparam int HB[2]  = '{42, 9};
    localparam int VA[2]  = '{224, 10};
    localparam int VF[2]  = '{12, 4};
    localparam int VW[2]  = '{7, 3};
    localparam int VB[2]  = '{20, 5};
    localparam int POL[2] = '{0, 1};

    typedef struct {
        int hpos; int vpos;
        int hblk; int vblk;
        int hsyn; int vsyn;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    int n[2]     = '{0, 0};
    int rgb_e[2] = '{0, 0};
    int ls_e[2]  = '{0, 0};
    int fs_e[2]  = '{0, 0};
    int sync_cnt = 0;
    int phase    = 0;
    int cyc      = 0;
    int last_ls_d = -1;
    int last_ls_s = -1;
    int last_fs_s = -1;

    function automatic int htot(input int c);
        return HA[c] + HF[c] + HW[c] + HB[c];
    endfunction

    function automatic int vtot(input int c);
        return VA[c] + VF[c] + VW[c] + VB[c];
    endfunction

    function automatic int blank_at(input int c, input int p);
        int h, v;
        h = p % htot(c);
        v = (p / htot(c)) % vtot(c);
        return (h >= HA[c] || v >= VA[c]) ? 1 : 0;
    endfunction

    // Outputs after n pixel ticks: position is n, registered decode is of n-1.
    function automatic exp_t expect_at(input int c, input int k);
        exp_t e;
        int h, v, hs0, vs0;
        e.hpos = k % htot(c);
        e.vpos = (k / htot(c)) % vtot(c);
        if (k == 0) begin
            e.hblk = 1; e.vblk = 1;
            e.hsyn = 1 - POL[c]; e.vsyn = 1 - POL[c];
        end else begin
            h = (k - 1) % htot(c);
            v = ((k - 1) / htot(c)) % vtot(c);
            hs0 = HA[c] + HF[c];
            vs0 = VA[c] + VF[c];
            e.hblk = (h >= HA[c]) ? 1 : 0;
            e.vblk = (v >= VA[c]) ? 1 : 0;
            e.hsyn = (h >= hs0 && h < hs0 + HW[c]) ? POL[c] : 1 - POL[c];
            e.vsyn = (v >= vs0 && v < vs0 + VW[c]) ? POL[c] : 1 - POL[c];
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: counts pixel ticks since the synchronised reset release.
    always @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_cnt = 0;
            for (int c = 0; c < 2; c++) begin
                n[c] = 0; rgb_e[c] = 0; ls_e[c] = 0; fs_e[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                ls_e[c] = 0; fs_e[c] = 0;
            end
            if (sync_cnt >= 2 && PCE) begin
                for (int c = 0; c < 2; c++) begin
                    rgb_e[c] = blank_at(c, n[c]) ? 0 : int'(iRGB);
                    n[c]++;
                    ls_e[c] = (n[c] % htot(c) == 0) ? 1 : 0;
                    fs_e[c] = (n[c] % (htot(c) * vtot(c)) == 0) ? 1 : 0;
                end
            end
            if (sync_cnt < 2) sync_cnt++;
        end
    end

    // Compare process: every cycle, both instances, on the falling edge.
    always @(negedge MCLK) begin
        exp_t e0, e1;
        cyc++;
        e0 = expect_at(0, n[0]);
        e1 = expect_at(1, n[1]);
        chk("d_hpos", int'(d_hpos), e0.hpos);
        chk("d_vpos", int'(d_vpos), e0.vpos);
        chk("d_hblk", int'(d_hblk), e0.hblk);
        chk("d_vblk", int'(d_vblk), e0.vblk);
        chk("d_hsyn", int'(d_hsyn), e0.hsyn);
        chk("d_vsyn", int'(d_vsyn), e0.vsyn);
        chk("d_rgb", int'(d_rgb), rgb_e[0]);
        chk("d_lstart", int'(d_ls), ls_e[0]);
        chk("d_fstart", int'(d_fs), fs_e[0]);
        chk("s_hpos", int'(s_hpos), e1.hpos);
        chk("s_vpos", int'(s_vpos), e1.vpos);
        chk("s_hblk", int'(s_hblk), e1.hblk);
        chk("s_vblk", int'(s_vblk), e1.vblk);
        chk("s_hsyn", int'(s_hsyn), e1.hsyn);
        chk("s_vsyn", int'(s_vsyn), e1.vsyn);
        chk("s_rgb", int'(s_rgb), rgb_e[1]);
        chk("s_lstart", int'(s_ls), ls_e[1]);
        chk("s_fstart", int'(s_fs), fs_e[1]);

        if (phase == 1) begin
            if (n[0] == 1) begin
                chk("lit_first_hpos", int'(d_hpos), 1);
                chk("lit_first_hblk", int'(d_hblk), 0);
                chk("lit_first_vblk", int'(d_vblk), 0);
            end
            if (n[0] == 100) chk("lit_rgb_act", int'(d_rgb), 'hABC);
            if (n[0] == 300) chk("lit_rgb_hblank", int'(d_rgb), 0);
            if (n[0] == 288) chk("lit_hblk_288", int'(d_hblk), 0);
            if (n[0] == 289) begin
                chk("lit_hpos_289", int'(d_hpos), 289);
                chk("lit_hblk_289", int'(d_hblk), 1);
            end
            if (n[0] == 310) chk("lit_hsyn_310", int'(d_hsyn), 1);
            if (n[0] == 311) chk("lit_hsyn_311", int'(d_hsyn), 0);
            if (n[0] == 342) chk("lit_hsyn_342", int'(d_hsyn), 0);
            if (n[0] == 343) chk("lit_hsyn_343", int'(d_hsyn), 1);
            if (n[0] == 384) begin
                chk("lit_lstart_384", int'(d_ls), 1);
                chk("lit_vpos_384", int'(d_vpos), 1);
            end
            if (n[1] == 17) chk("lit_s_hsyn_17", int'(s_hsyn), 0);
            if (n[1] == 18) chk("lit_s_hsyn_18", int'(s_hsyn), 1);
            if (n[1] == 23) chk("lit_s_hsyn_23", int'(s_hsyn), 1);
            if (n[1] == 24) chk("lit_s_hsyn_24", int'(s_hsyn), 0);
            if (n[1] == 448) chk("lit_s_vsyn_448", int'(s_vsyn), 0);
            if (n[1] == 449) chk("lit_s_vsyn_449", int'(s_vsyn), 1);
            if (n[1] == 704) begin
                chk("lit_s_fstart_704", int'(s_fs), 1);
                chk("lit_s_hpos_704", int'(s_hpos), 0);
                chk("lit_s_vpos_704", int'(s_vpos), 0);
            end
            if (d_ls) begin
                if (last_ls_d >= 0) chk("d_lstart_period", cyc - last_ls_d, 384);
                last_ls_d = cyc;
            end
            if (s_ls) begin
                if (last_ls_s >= 0) chk("s_lstart_period", cyc - last_ls_s, 32);
                last_ls_s = cyc;
            end
            if (s_fs) begin
                if (last_fs_s >= 0) chk("s_fstart_period", cyc - last_fs_s, 704);
                last_fs_s = cyc;
            end
        end
    end

    initial begin
        int burst;
        int burst_hi;
        burst    = 0;
        burst_hi = 0;

        repeat (3) @(negedge MCLK);
        chk("rst_d_hpos", int'(d_hpos), 0);
        chk("rst_d_hblk", int'(d_hblk), 1);
        chk("rst_d_hsyn", int'(d_hsyn), 1);
        chk("rst_s_hsyn", int'(s_hsyn), 0);
        chk("rst_d_rgb", int'(d_rgb), 0);

        #2;
        RESET_N = 1'b1;
        PCE     = 1'b1;
        iRGB    = 12'hABC;
        phase   = 1;

        for (int k = 0; k < 40000; k++) begin
            @(negedge MCLK);
            if (n[0] >= 100 * 384 + 150) break;
        end
        chk("pre_rst_hpos", int'(d_hpos), 150);
        chk("pre_rst_vpos", int'(d_vpos), 100);

        #2;
        RESET_N = 1'b0;
        phase   = 2;
        #1;
        chk("mid_rst_hpos", int'(d_hpos), 0);
        chk("mid_rst_vpos", int'(d_vpos), 0);
        chk("mid_rst_hblk", int'(d_hblk), 1);
        chk("mid_rst_vblk", int'(d_vblk), 1);
        chk("mid_rst_hsyn", int'(d_hsyn), 1);
        chk("mid_rst_vsyn", int'(d_vsyn), 1);
        chk("mid_rst_rgb", int'(d_rgb), 0);
        chk("mid_rst_ls", int'(d_ls), 0);
        chk("mid_rst_fs", int'(d_fs), 0);
        chk("mid_rst_s_vsyn", int'(s_vsyn), 0);

        repeat (2) @(negedge MCLK);
        #2;
        RESET_N = 1'b1;
        phase   = 3;

        for (int k = 0; k < 8000; k++) begin
            @(negedge MCLK);
            #2;
            if (burst == 0) begin
                burst_hi = int'($urandom_range(0, 1));
                burst    = int'($urandom_range(5, 60));
            end
            burst--;
            PCE  = (burst_hi != 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            iRGB = 12'($urandom);
            if (k == 3000 || $urandom_range(0, 1999) == 0) begin
                RESET_N = 1'b0;
                @(negedge MCLK);
                #2;
                RESET_N = 1'b1;
            end
        end

        @(negedge MCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
